// File: rtl/ext_pkg.sv
// Shared types and widths for the immediate-extender arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: ext_op_t extension-op encoding, IMM_W / WORD_W default widths.
package ext_pkg;

  localparam int IMM_W  = 16;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    EXT_ZERO = 2'b00,
    EXT_SIGN = 2'b01,
    EXT_LUI  = 2'b10,
    EXT_RSVD = 2'b11
  } ext_op_t;

endpackage

// File: rtl/imm_ext.sv
// Immediate extender: widens an IW-bit immediate to OW bits per ext_op_t.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows inputs.
// Ports: imm (IW) and op (ext_op_t) in, out (OW) out. OW is expected to be 2*IW.
module imm_ext
  import ext_pkg::*;
#(
  parameter int IW = IMM_W,
  parameter int OW = WORD_W
) (
  input  logic    [IW-1:0] imm,
  input  ext_op_t          op,
  output logic    [OW-1:0] out
);

  always_comb begin
    out = {{(OW-IW){1'b0}}, imm};
    case (op)
      EXT_ZERO: out = {{(OW-IW){1'b0}}, imm};
      EXT_SIGN: out = {{(OW-IW){imm[IW-1]}}, imm};
      EXT_LUI:  out = {imm, {(OW-IW){1'b0}}};
      // Reserved encoding degrades to zero-extension.
      default:  out = {{(OW-IW){1'b0}}, imm};
    endcase
  end

endmodule

// File: rtl/ext_arbiter.sv
// Two-port arbiter sharing one immediate extender, with a registered valid/ready output.
// Latency: grant -> out_valid is 1 cycle; 1 result/cycle while out_ready=1.
// Backpressure: FULL && !out_ready holds the result and suppresses both grants.
// Ports: clk, reset (sync, active-high); req/imm/op per port in, gnt per port out;
//        out_valid/out_id/out result out, out_ready in.
// Option: EXT_ARB_ROUND_ROBIN_EN selects round-robin; otherwise port 0 has fixed priority.
module ext_arbiter
  import ext_pkg::*;
#(
  parameter int IW = IMM_W,
  parameter int OW = WORD_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic [IW-1:0] imm0,
  input  logic [1:0]    op0,
  input  logic          req1,
  input  logic [IW-1:0] imm1,
  input  logic [1:0]    op1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          out_valid,
  output logic          out_id,
  output logic [OW-1:0] out,
  input  logic          out_ready
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]    state;
  logic          can_accept;
  logic          grant_any;
  logic [IW-1:0] imm_sel;
  logic [1:0]    op_sel;
  logic [OW-1:0] ext_res;

  assign out_valid = (state == ST_FULL);

  // Folding reset in here keeps both grants low while reset is held.
  assign can_accept = !reset && ((state == ST_EMPTY) || out_ready);

`ifdef EXT_ARB_ROUND_ROBIN_EN
  logic last;

  // On contention the port that did not win last time goes next.
  assign gnt0 = can_accept && req0 && (!req1 || last);
  assign gnt1 = can_accept && req1 && (!req0 || !last);
`else
  assign gnt0 = can_accept && req0;
  assign gnt1 = can_accept && req1 && !req0;
`endif

  assign grant_any = gnt0 || gnt1;

  // Mux select is only meaningful on a grant edge, so gnt1 alone picks the winner.
  assign imm_sel = gnt1 ? imm1 : imm0;
  assign op_sel  = gnt1 ? op1  : op0;

  imm_ext #(
    .IW (IW),
    .OW (OW)
  ) u_imm_ext (
    .imm (imm_sel),
    .op  (ext_op_t'(op_sel)),
    .out (ext_res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_EMPTY;
      out    <= '0;
      out_id <= 1'b0;
    end else if (grant_any) begin
      // A grant while FULL implies out_ready: pop and refill on the same edge.
      state  <= ST_FULL;
      out    <= ext_res;
      out_id <= gnt1;
    end else if (state == ST_FULL && out_ready) begin
      state <= ST_EMPTY;
    end
  end

`ifdef EXT_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      last <= 1'b1;
    end else if (grant_any) begin
      last <= gnt1;
    end
  end
`endif

endmodule

// File: tb/tb_ext_arbiter.sv
// Self-checking bench for ext_arbiter: directed scenarios then randomized traffic,
// all compared every cycle against a behavioural model of the arbiter/output stage.
module tb_ext_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [15:0] imm0, imm1;
  logic [1:0]  op0, op1;
  logic        gnt0, gnt1;
  logic        out_valid;
  logic        out_id;
  logic [31:0] out;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  // Model state
  logic        m_valid;
  logic [31:0] m_out;
  logic        m_id;
`ifdef EXT_ARB_ROUND_ROBIN_EN
  logic        m_last;
`endif
  logic        e_g0, e_g1;

  always #5 clk = ~clk;

  ext_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .imm0      (imm0),
    .op0       (op0),
    .req1      (req1),
    .imm1      (imm1),
    .op1       (op1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .out_valid (out_valid),
    .out_id    (out_id),
    .out       (out),
    .out_ready (out_ready)
  );

  // Extension from arithmetic rather than bit concatenation.
  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] op);
    int unsigned v;
    v = imm;
    if (op == 2'b01) begin
      if (imm >= 16'h8000) v = v + 32'hffff_0000;
    end else if (op == 2'b10) begin
      v = v * 65536;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic predict();
    logic ok;
    ok   = !reset && (!m_valid || out_ready);
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    if (ok) begin
      if (req0 && req1) begin
`ifdef EXT_ARB_ROUND_ROBIN_EN
        if (m_last) e_g0 = 1'b1;
        else        e_g1 = 1'b1;
`else
        e_g0 = 1'b1;
`endif
      end else if (req0) begin
        e_g0 = 1'b1;
      end else if (req1) begin
        e_g1 = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_out   = 32'h0;
    m_id    = 1'b0;
`ifdef EXT_ARB_ROUND_ROBIN_EN
    m_last  = 1'b1;
`endif
  endtask

  // Called at posedge+1; checks mid-cycle, advances the model on the edge.
  task automatic cycle();
    @(negedge clk);
    predict();
    chk("gnt0", gnt0, e_g0);
    chk("gnt1", gnt1, e_g1);
    chk("out_valid", out_valid, m_valid);
    chk("out", out, m_out);
    chk("out_id", out_id, m_id);
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else if (e_g0 || e_g1) begin
      m_valid = 1'b1;
      m_out   = e_g1 ? ref_ext(imm1, op1) : ref_ext(imm0, op0);
      m_id    = e_g1;
`ifdef EXT_ARB_ROUND_ROBIN_EN
      m_last  = e_g1;
`endif
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  logic [31:0] held_exp;
  logic        rr_exp [4];

  initial begin
    reset = 1'b1; out_ready = 1'b0;
    req0 = 1'b1; imm0 = 16'h0; op0 = 2'b00;
    req1 = 1'b1; imm1 = 16'h0; op1 = 2'b00;
    @(posedge clk); #1;
    model_reset();

    // Reset state: requests high yet no grants.
    cycle();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_out", out, 32'h0);

    // Port 0 alone, sign-extend ffff.
    reset = 1'b0; out_ready = 1'b1; req1 = 1'b0;
    imm0 = 16'hffff; op0 = 2'b01;
    #1 chk("t1_gnt0", gnt0, 1'b1);
    cycle();
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_out", out, 32'hffff_ffff);
    chk("t1_id", out_id, 1'b0);

    // Port 1 alone, zero-ext then load-upper back to back.
    req0 = 1'b0;
    req1 = 1'b1; imm1 = 16'hffff; op1 = 2'b00;
    cycle();
    chk("t2_out_a", out, 32'h0000_ffff);
    chk("t2_id_a", out_id, 1'b1);
    imm1 = 16'h1234; op1 = 2'b10;
    cycle();
    chk("t2_out_b", out, 32'h1234_0000);
    chk("t2_valid_b", out_valid, 1'b1);

    // Continuous contention.
    req0 = 1'b1; imm0 = 16'h0011; op0 = 2'b00;
    req1 = 1'b1; imm1 = 16'h0022; op1 = 2'b00;
`ifdef EXT_ARB_ROUND_ROBIN_EN
    rr_exp = '{1'b0, 1'b1, 1'b0, 1'b1};
    held_exp = 32'h0000_0022;
`else
    rr_exp = '{1'b0, 1'b0, 1'b0, 1'b0};
    held_exp = 32'h0000_0011;
`endif
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk($sformatf("t3_id%0d", i), out_id, rr_exp[i]);
`ifndef EXT_ARB_ROUND_ROBIN_EN
      chk($sformatf("t3_gnt1_%0d", i), gnt1, 1'b0);
`endif
    end

    // Backpressure while FULL.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("t4_gnt0_%0d", i), gnt0, 1'b0);
      chk($sformatf("t4_gnt1_%0d", i), gnt1, 1'b0);
      cycle();
      chk($sformatf("t4_out%0d", i), out, held_exp);
      chk($sformatf("t4_valid%0d", i), out_valid, 1'b1);
    end
    out_ready = 1'b1;
    cycle();
    chk("t4_refill_valid", out_valid, 1'b1);
    chk("t4_refill_id", out_id, 1'b0);
    chk("t4_refill_out", out, 32'h0000_0011);

    // Reset while FULL holding 80000000.
    req1 = 1'b0; imm0 = 16'h8000; op0 = 2'b10;
    cycle();
    chk("t5_pre_out", out, 32'h8000_0000);
    reset = 1'b1; req1 = 1'b1;
    cycle();
    chk("t5_valid", out_valid, 1'b0);
    chk("t5_out", out, 32'h0);
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
    cycle();
    chk("t5_no_replay", out_valid, 1'b0);
    req0 = 1'b1; req1 = 1'b1; imm0 = 16'h0005; imm1 = 16'h0006;
    cycle();
    chk("t5_first_id", out_id, 1'b0);

    // Reserved op behaves as zero-extend.
    req1 = 1'b0; imm0 = 16'h8001; op0 = 2'b11;
    cycle();
    chk("t6_out", out, 32'h0000_8001);

    // Randomized traffic with requesters that hold until granted or occasionally drop.
    req0 = 1'b0; req1 = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      reset     = ($urandom_range(0, 199) == 0);
      if (e_g0 || !req0) begin
        req0 = ($urandom_range(0, 9) < 6);
        imm0 = $urandom_range(0, 1) ? 16'($urandom) : ($urandom_range(0, 1) ? 16'h8000 : 16'h7fff);
        op0  = 2'($urandom);
      end else if ($urandom_range(0, 19) == 0) begin
        req0 = 1'b0;
      end
      if (e_g1 || !req1) begin
        req1 = ($urandom_range(0, 9) < 6);
        imm1 = 16'($urandom);
        op1  = 2'($urandom);
      end else if ($urandom_range(0, 19) == 0) begin
        req1 = 1'b0;
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
